// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC memory-port arbiter.
//   arb_state_e    : arbiter FSM states (IDLE / ISSUE / WAIT / RESP)
//   OP_*           : RAM opcode constants; fetches always use OP_LD_WORD
//   ADDR_W_DEFAULT : default RAM byte-address width
package sparc_mem_pkg;

  localparam int ADDR_W_DEFAULT = 9;

  localparam logic [5:0] OP_LD_WORD  = 6'h00;
  localparam logic [5:0] OP_LD_UBYTE = 6'h01;
  localparam logic [5:0] OP_LD_UHALF = 6'h02;
  localparam logic [5:0] OP_ST_WORD  = 6'h04;
  localparam logic [5:0] OP_ST_BYTE  = 6'h05;
  localparam logic [5:0] OP_ST_HALF  = 6'h06;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester tie-break for the memory port.
//   clk, rst     : clock, asynchronous active-high reset
//   f_req, d_req : fetch / data requests
//   take         : the current grant is being accepted (arbiter idle)
//   grant_valid  : at least one requester is asking
//   grant_data   : 0 = fetch wins, 1 = data wins
// A single last-served flop breaks ties in favour of the side not served
// last. It resets to "fetch", so the first contested grant goes to data.
module mem_arb_rr (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  input  logic take,
  output logic grant_valid,
  output logic grant_data
);

  logic last_data_r;

  // Grant selection from the live requests and the last-served side.
  always_comb begin
    grant_valid = f_req | d_req;
    grant_data  = 1'b0;
    if (f_req && d_req) begin
      grant_data = ~last_data_r;
    end else if (d_req) begin
      grant_data = 1'b1;
    end else begin
      grant_data = 1'b0;
    end
  end

  // Last-served flop, updated only when a grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data_r <= 1'b0;
    end else if (take) begin
      last_data_r <= grant_data;
    end else begin
      last_data_r <= last_data_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch (F_*) and load/store (D_*).
//   Clk, RESET          : clock, asynchronous active-high reset
//   F_req/F_addr        : fetch request; F_ack pulse, F_data result word
//   D_req/D_addr/D_op/D_wdata : data request; D_ack pulse, D_rdata result
//   RAM_enable/RAM_OpCode/RAM_addr/RAM_wdata : RAM command, held ISSUE..WAIT
//   RAM_rdata, MFC      : RAM read data and completion strobe
//   busy, grant_id      : FSM not idle; owner of current/last transaction
//   timeout_err         : sticky abort flag
// Optional feature macro ARB_TIMEOUT_EN: abort a WAIT that sees no MFC for
// TIMEOUT cycles, returning a zero word. Without it the port waits forever.
// All outputs are flops with asynchronous reset, so RAM_enable and busy
// drop the moment RESET rises.
module mem_port_arbiter
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              F_req,
  input  logic [ADDR_W-1:0] F_addr,
  output logic              F_ack,
  output logic [31:0]       F_data,
  input  logic              D_req,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [5:0]        D_op,
  input  logic [31:0]       D_wdata,
  output logic              D_ack,
  output logic [31:0]       D_rdata,
  output logic              RAM_enable,
  output logic [5:0]        RAM_OpCode,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic [31:0]       RAM_wdata,
  input  logic [31:0]       RAM_rdata,
  input  logic              MFC,
  output logic              busy,
  output logic              grant_id,
  output logic              timeout_err
);

  arb_state_e        state_r;
  arb_state_e        state_s;
  logic              grant_valid_s;
  logic              grant_data_s;
  logic              take_s;
  logic              mfc_hit_s;
  logic              abort_s;
  logic              done_s;
  logic [31:0]       resp_word_s;
  logic              ram_enable_r;
  logic              busy_r;
  logic              f_ack_r;
  logic              d_ack_r;
  logic              grant_id_r;
  logic [5:0]        ram_op_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [31:0]       ram_wdata_r;
  logic [31:0]       f_data_r;
  logic [31:0]       d_rdata_r;

  mem_arb_rr u_arb (
    .clk         (Clk),
    .rst         (RESET),
    .f_req       (F_req),
    .d_req       (D_req),
    .take        (take_s),
    .grant_valid (grant_valid_s),
    .grant_data  (grant_data_s)
  );

  // New requests are only looked at in IDLE; MFC only counts in WAIT.
  assign take_s      = (state_r == ST_IDLE) & grant_valid_s;
  assign mfc_hit_s   = (state_r == ST_WAIT) & MFC;
  assign done_s      = mfc_hit_s | abort_s;
  assign resp_word_s = mfc_hit_s ? RAM_rdata : 32'h0000_0000;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             timeout_err_r;

  // A real MFC on the final cycle still wins over the abort.
  assign abort_s = (state_r == ST_WAIT) & ~MFC & (wait_cnt_r == CNT_W'(TIMEOUT));

  // WAIT-cycle counter: zeroed while in ISSUE (i.e. on WAIT entry).
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_ISSUE) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && !MFC && !abort_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky abort flag; only RESET clears it.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      timeout_err_r <= 1'b0;
    end else if (abort_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign abort_s     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      ram_enable_r <= 1'b0;
      busy_r       <= 1'b0;
      f_ack_r      <= 1'b0;
      d_ack_r      <= 1'b0;
    end else begin
      ram_enable_r <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      busy_r       <= (state_s != ST_IDLE);
      f_ack_r      <= (state_s == ST_RESP) && !grant_id_r;
      d_ack_r      <= (state_s == ST_RESP) && grant_id_r;
    end
  end

  // Command latch: captured at grant and held until the next grant.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      grant_id_r  <= 1'b0;
      ram_op_r    <= 6'h00;
      ram_addr_r  <= '0;
      ram_wdata_r <= 32'h0000_0000;
    end else if (take_s && grant_data_s) begin
      grant_id_r  <= 1'b1;
      ram_op_r    <= D_op;
      ram_addr_r  <= D_addr;
      ram_wdata_r <= D_wdata;
    end else if (take_s) begin
      grant_id_r  <= 1'b0;
      ram_op_r    <= OP_LD_WORD;
      ram_addr_r  <= F_addr;
      ram_wdata_r <= 32'h0000_0000;
    end else begin
      grant_id_r  <= grant_id_r;
      ram_op_r    <= ram_op_r;
      ram_addr_r  <= ram_addr_r;
      ram_wdata_r <= ram_wdata_r;
    end
  end

  // Result words: only the owner's register is touched (stores included).
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      f_data_r  <= 32'h0000_0000;
      d_rdata_r <= 32'h0000_0000;
    end else if (done_s && grant_id_r) begin
      d_rdata_r <= resp_word_s;
    end else if (done_s) begin
      f_data_r  <= resp_word_s;
    end else begin
      f_data_r  <= f_data_r;
      d_rdata_r <= d_rdata_r;
    end
  end

  assign RAM_enable = ram_enable_r;
  assign busy       = busy_r;
  assign F_ack      = f_ack_r;
  assign D_ack      = d_ack_r;
  assign grant_id   = grant_id_r;
  assign RAM_OpCode = ram_op_r;
  assign RAM_addr   = ram_addr_r;
  assign RAM_wdata  = ram_wdata_r;
  assign F_data     = f_data_r;
  assign D_rdata    = d_rdata_r;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, RAM byte-address width.
REQ-002 Parameter TIMEOUT, default 15, max WAIT cycles before abort; used only with ARB_TIMEOUT_EN.
REQ-003 Clk  in  1  system clock; all state changes on rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 F_req  in  1  instruction-fetch request; held until F_ack.
REQ-006 F_addr  in  ADDR_W  fetch address.
REQ-007 F_ack  out  1  one-cycle pulse, fetch done.
REQ-008 F_data  out  32  fetched word; valid from F_ack until next fetch completes.
REQ-009 D_req  in  1  load/store request; held until D_ack.
REQ-010 D_addr  in  ADDR_W  data address.
REQ-011 D_op  in  6  RAM opcode for data access.
REQ-012 D_wdata  in  32  store data.
REQ-013 D_ack  out  1  one-cycle pulse, data access done.
REQ-014 D_rdata  out  32  load result; valid from D_ack until next data access completes.
REQ-015 RAM_enable  out  1  RAM strobe.
REQ-016 RAM_OpCode  out  6  opcode to RAM.
REQ-017 RAM_addr  out  ADDR_W  address to RAM.
REQ-018 RAM_wdata  out  32  write data to RAM.
REQ-019 RAM_rdata  in  32  read data from RAM.
REQ-020 MFC  in  1  memory-function-complete from RAM.
REQ-021 busy  out  1  high in any state except IDLE.
REQ-022 grant_id  out  1  0 = fetch, 1 = data; owner of current or last transaction.
REQ-023 timeout_err  out  1  sticky abort flag.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE: one req high -> latch its addr/op/wdata, set grant_id, go ISSUE; neither -> stay.
REQ-026 Both req high in IDLE -> grant the requester not served last; first arbitration after reset grants data.
REQ-027 Fetch transactions use opcode OP_LD_WORD and wdata 0.
REQ-028 ISSUE: RAM_enable=1, RAM_* from latched registers; unconditionally go WAIT.
REQ-029 WAIT: RAM_enable held 1, RAM_* stable; MFC=1 -> capture RAM_rdata into owner's data output, go RESP.
REQ-030 RESP: owner's ack=1 one cycle, RAM_enable=0; go IDLE.
REQ-031 Latency: req sampled in IDLE at edge 0 -> ISSUE cycle 1 -> WAIT from cycle 2; MFC sampled at edge k -> ack high in cycle k+1; minimum 3 cycles req-to-ack.
REQ-032 MFC outside WAIT ignored.
REQ-033 Req dropped after grant: transaction completes, ack still pulses.
REQ-034 Req for new transaction sampled only in IDLE; back-to-back requests cost one IDLE cycle between transactions.
REQ-035 Stores also capture RAM_rdata into D_rdata; no other output side effect.
REQ-036 Non-owner data output and ack never change during a transaction.

Reset
REQ-037 RESET=1 asynchronously forces IDLE; F_ack=D_ack=RAM_enable=busy=0; RAM_OpCode=0, RAM_addr=0, RAM_wdata=0; F_data=D_rdata=0; grant_id=0; last-served = fetch; timeout_err=0.
REQ-038 RESET mid-transaction aborts with no ack; RAM_enable drops with RESET, not at the next edge.

Configuration
REQ-039 Macro ARB_TIMEOUT_EN.
REQ-040 Defined: counter cleared on WAIT entry, increments each WAIT cycle without MFC; reaching TIMEOUT -> timeout_err=1 (sticky until RESET), owner data=32'h0, go RESP.
REQ-041 Undefined: WAIT indefinitely; timeout_err tied 0; no counter logic.

Structure
REQ-042 Package sparc_mem_pkg holds state enum, OP_LD_WORD and other RAM opcode constants, and the ADDR_W default.
REQ-043 Sub-module mem_arb_rr: tie-break/last-served flop, outputs the grant.

Verification
REQ-044 F_req, F_addr=0, RAM returns 32'h8200_2005, MFC 2 cycles after ISSUE -> F_ack 1 cycle, F_data=32'h82002005, D_ack never.
REQ-045 F_req and D_req together after reset -> data first; then fetch; D_ack precedes F_ack; RAM_addr sequence D_addr then F_addr.
REQ-046 Store, D_addr=224, D_wdata=25 -> RAM_wdata=25 and RAM_addr=224 stable through WAIT; D_ack after MFC.
REQ-047 RESET pulsed in WAIT -> RAM_enable 0 immediately, busy 0, no ack; new F_req served normally.
REQ-048 ARB_TIMEOUT_EN, TIMEOUT=15, MFC never -> ack in cycle 18 after req, data 0, timeout_err 1 until RESET.
REQ-049 MFC pulse while IDLE, then normal fetch -> stray pulse ignored, fetch still waits for its own MFC.
